// File: rtl/rand_target_picker.sv
// rand_target_picker: turns the free-running rand8bits byte into a game
// target index 0..N_TARGETS-1 by rejection sampling. Values that are out of
// range, or that repeat the previous target, are discarded. After MAX_TRIES
// rejected samples a deterministic fallback (previous target + 1, wrapping)
// is used, so a result always arrives within a fixed worst-case latency.
// The random byte port is named rand_byte because "rand" is a reserved word.
module rand_target_picker #(
  parameter int N_TARGETS = 9,
  parameter int IDX_W     = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rand_byte,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [IDX_W-1:0] target,
  output logic             fallback
);

  localparam int CNT_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [CNT_W-1:0] LAST_TRY  = CNT_W'(MAX_TRIES - 1);
  localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(N_TARGETS - 1);
  localparam logic [IDX_W:0]   N_TGT_EXT = (IDX_W + 1)'(N_TARGETS);

  typedef enum logic {
    IDLE,
    SAMPLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] try_cnt;
  logic [IDX_W-1:0] last;
  logic             have_last;

  logic [IDX_W-1:0] cand;
  logic             in_range;
  logic             not_repeat;
  logic             accept;
  logic [IDX_W-1:0] fb_value;

  // Candidate qualification and fallback value, evaluated on the live rand byte.
  always_comb begin
    cand       = rand_byte[IDX_W-1:0];
    // Extra bit so N_TARGETS == 2^IDX_W is representable.
    in_range   = ({1'b0, cand} < N_TGT_EXT);
    not_repeat = !have_last || (cand != last);
    accept     = in_range && not_repeat;
    fb_value   = '0;
    if (have_last && (last != TOP_IDX)) begin
      fb_value = last + IDX_W'(1);
    end
  end

  // Control FSM with registered outputs; reset aborts any transaction silently.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      try_cnt   <= '0;
      last      <= '0;
      have_last <= 1'b0;
      target    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      fallback  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // valid/fallback live only for the first IDLE cycle after a decision.
          valid    <= 1'b0;
          fallback <= 1'b0;
          if (req) begin
            state   <= SAMPLE;
            busy    <= 1'b1;
            try_cnt <= '0;
          end
        end
        SAMPLE: begin
          if (accept) begin
            target    <= cand;
            last      <= cand;
            have_last <= 1'b1;
            fallback  <= 1'b0;
            valid     <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (try_cnt == LAST_TRY) begin
            target    <= fb_value;
            last      <= fb_value;
            have_last <= 1'b1;
            fallback  <= 1'b1;
            valid     <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            try_cnt <= try_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_target_picker.sv
// Directed bench for rand_target_picker (N_TARGETS=9, IDX_W=4, MAX_TRIES=8).
module tb_rand_target_picker;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rand_byte;
  logic       req;
  logic       busy;
  logic       valid;
  logic [3:0] target;
  logic       fallback;

  int tests  = 0;
  int failed = 0;

  rand_target_picker #(
    .N_TARGETS(9),
    .IDX_W    (4),
    .MAX_TRIES(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rand_byte(rand_byte),
    .req      (req),
    .busy     (busy),
    .valid    (valid),
    .target   (target),
    .fallback (fallback)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] r0;    // rand during first SAMPLE cycle
    logic [7:0] r1;    // rand during later SAMPLE cycles
    int         lat;   // SAMPLE cycles until decision
    logic [3:0] tgt;
    logic       fb;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One request; rand=r0 on the first SAMPLE edge, r1 afterwards.
  task automatic run_txn(input logic [7:0] r0, input logic [7:0] r1,
                         input int exp_lat, input logic [3:0] exp_tgt,
                         input logic exp_fb, input string name);
    int  cyc;
    logic got;
    req       = 1'b1;
    rand_byte = r0;
    tick();
    req = 1'b0;
    check({name, " busy"}, int'(busy), 1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      rand_byte = (cyc == 0) ? r0 : r1;
      tick();
      cyc++;
      if (valid) got = 1'b1;
    end
    check({name, " valid_seen"}, int'(got), 1);
    check({name, " latency"}, cyc, exp_lat);
    check({name, " target"}, int'(target), int'(exp_tgt));
    check({name, " fallback"}, int'(fallback), int'(exp_fb));
    $display("[TB] txn %s: lat=%0d target=%0d fallback=%0b", name, cyc, target, fallback);
    tick();
    check({name, " valid_drop"}, int'(valid), 0);
    check({name, " fb_drop"}, int'(fallback), 0);
    check({name, " idle"}, int'(busy), 0);
  endtask

  initial begin
    int exp_seq[4];
    int cyc;
    logic got;

    vecs[0] = '{r0: 8'h35, r1: 8'h35, lat: 1, tgt: 4'd5, fb: 1'b0}; // first, no last
    vecs[1] = '{r0: 8'h25, r1: 8'h07, lat: 2, tgt: 4'd7, fb: 1'b0}; // repeat rejected
    vecs[2] = '{r0: 8'hFF, r1: 8'hFF, lat: 8, tgt: 4'd8, fb: 1'b1}; // fallback 7+1
    vecs[3] = '{r0: 8'hFF, r1: 8'hFF, lat: 8, tgt: 4'd0, fb: 1'b1}; // fallback wraps
    vecs[4] = '{r0: 8'h13, r1: 8'h13, lat: 1, tgt: 4'd3, fb: 1'b0}; // upper bits ignored
    vecs[5] = '{r0: 8'h09, r1: 8'h02, lat: 2, tgt: 4'd2, fb: 1'b0}; // cand==N rejected
    vecs[6] = '{r0: 8'h08, r1: 8'h08, lat: 1, tgt: 4'd8, fb: 1'b0}; // cand==N-1 ok
    vecs[7] = '{r0: 8'h03, r1: 8'h03, lat: 1, tgt: 4'd3, fb: 1'b0};

    // Reset held with req active
    reset     = 1'b0;
    req       = 1'b1;
    rand_byte = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst target", int'(target), 0);
      check("rst valid", int'(valid), 0);
      check("rst busy", int'(busy), 0);
      check("rst fallback", int'(fallback), 0);
    end
    reset = 1'b1;
    req   = 1'b0;
    tick();
    tick();
    check("post-rst busy", int'(busy), 0);
    check("post-rst valid", int'(valid), 0);
    $display("[TB] txn reset: outputs idle");

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].r0, vecs[i].r1, vecs[i].lat, vecs[i].tgt, vecs[i].fb,
              $sformatf("vec%0d", i));
    end

    // Back-to-back with req held high; last is 3 here
    exp_seq = '{1, 2, 1, 2};
    req       = 1'b1;
    rand_byte = 8'h01;
    tick();
    check("b2b start busy", int'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      rand_byte = (k % 2 == 0) ? 8'h01 : 8'h02;
      tick();
      check($sformatf("b2b%0d valid", k), int'(valid), 1);
      check($sformatf("b2b%0d target", k), int'(target), exp_seq[k]);
      $display("[TB] txn b2b%0d: target=%0d fallback=%0b", k, target, fallback);
      tick();
      check($sformatf("b2b%0d gap", k), int'(valid), 0);
      check($sformatf("b2b%0d rebusy", k), int'(busy), 1);
    end
    // Held rand=01: accept 1 (last 2), then repeat forces fallback 2
    rand_byte = 8'h01;
    tick();
    check("hold1 valid", int'(valid), 1);
    check("hold1 target", int'(target), 1);
    check("hold1 fallback", int'(fallback), 0);
    $display("[TB] txn hold1: target=%0d fallback=%0b", target, fallback);
    tick();
    check("hold2 busy", int'(busy), 1);
    req = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (valid) got = 1'b1;
    end
    check("hold2 valid_seen", int'(got), 1);
    check("hold2 latency", cyc, 8);
    check("hold2 target", int'(target), 2);
    check("hold2 fallback", int'(fallback), 1);
    $display("[TB] txn hold2: target=%0d fallback=%0b", target, fallback);
    tick();
    check("hold2 idle", int'(busy), 0);

    // Reset during the third SAMPLE cycle
    rand_byte = 8'hFF;
    req       = 1'b1;
    tick();
    req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (valid) got = 1'b1;
    end
    reset = 1'b0;
    tick();
    check("abort busy", int'(busy), 0);
    check("abort valid", int'(valid), 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid) got = 1'b1;
    end
    check("abort no_valid", int'(got), 0);
    $display("[TB] txn abort: busy=%0b", busy);
    run_txn(8'h05, 8'h05, 1, 4'd5, 1'b0, "post-abort");

    // last=5 now; reset must clear have_last so 5 is accepted again
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_txn(8'h05, 8'h05, 1, 4'd5, 1'b0, "post-reset-repeat");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
